// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer FSM encoding and the buffered command record
// used by the ALU command sequencer.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CMD_W = 34;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    function automatic logic is_divz(input cmd_t c);
        return (c.sel == OP_DIV) && (c.b == 16'h0000);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with separate occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, drives them one at a time into the external ALU,
// waits the settle time and returns the captured results in order.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_sel,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    output logic [15:0]      alu_ina,
    output logic [15:0]      alu_inb,
    output logic [1:0]       alu_sel,
    input  logic [15:0]      alu_out,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_overflow,
    output logic [1:0]       res_sel,
    output logic             res_divz,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_count
);

    state_t                       state;
    state_t                       next;
    cmd_t                         in_cmd;
    cmd_t                         head;
    logic [CMD_W-1:0]             head_bits;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH):0]       count;
    logic                         push;
    logic                         pop;
    logic                         capture;
    logic                         res_done;
    logic                         divz;
    logic [SETTLE_W-1:0]          settle_cnt;

    assign in_cmd    = '{sel: cmd_sel, a: cmd_a, b: cmd_b};
    assign head      = cmd_t'(head_bits);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count != '0) || (state != ST_IDLE);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE: begin
                if (!empty) next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) next = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) next = empty ? ST_IDLE : ST_SETTLE;
            end
            default: next = ST_IDLE;
        endcase
    end

    // HOLD always has res_valid set, so res_ready alone completes it.
    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        res_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pop = !empty;
            end
            ST_SETTLE: begin
                capture = (settle_cnt == '0);
            end
            ST_HOLD: begin
                res_done = res_ready;
                pop      = res_ready && !empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ina    <= '0;
            alu_inb    <= '0;
            alu_sel    <= '0;
            divz       <= 1'b0;
            settle_cnt <= '0;
        end else if (pop) begin
            alu_ina    <= head.a;
            alu_inb    <= head.b;
            alu_sel    <= head.sel;
            divz       <= is_divz(head);
            settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
        end else if (state == ST_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_sel      <= '0;
            res_divz     <= 1'b0;
            ovf_count    <= '0;
        end else if (capture) begin
            res_valid    <= 1'b1;
            res_data     <= alu_out;
            res_overflow <= alu_overflow;
            res_sel      <= alu_sel;
            res_divz     <= divz;
            if (alu_overflow && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end else if (res_done) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 16-bit ALU
// attached to the alu_* ports.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH      = 4;
    localparam int SETTLE_CYC = 1;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [15:0]      alu_ina;
    logic [15:0]      alu_inb;
    logic [1:0]       alu_sel;
    logic [15:0]      alu_out;
    logic             alu_overflow;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_overflow;
    logic [1:0]       res_sel;
    logic             res_divz;
    logic             busy;
    logic [CNT_W-1:0] ovf_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DEPTH      (DEPTH),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sel      (cmd_sel),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_ina      (alu_ina),
        .alu_inb      (alu_inb),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_sel      (res_sel),
        .res_divz     (res_divz),
        .busy         (busy),
        .ovf_count    (ovf_count)
    );

    function automatic logic [16:0] ref_alu(input logic [1:0] s,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] p;
        p = '0;
        ref_alu = '0;
        case (s)
            OP_ADD: ref_alu = {1'b0, a} + {1'b0, b};
            OP_SUB: ref_alu = {a < b, 16'(a - b)};
            OP_MUL: begin
                p = 32'(a) * 32'(b);
                ref_alu = {|p[31:16], p[15:0]};
            end
            default: ref_alu = (b == 16'h0) ? {1'b0, 16'hFFFF}
                                            : {1'b0, 16'(a / b)};
        endcase
    endfunction

    always_comb {alu_overflow, alu_out} = ref_alu(alu_sel, alu_ina, alu_inb);

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic [1:0]  sel;
        logic        divz;
    } exp_t;

    exp_t        q[$];
    exp_t        e_pop;
    exp_t        e_push;
    logic [16:0] r;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change only at posedge+1, so negedge values hold at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    check("sb_spurious", 32'd1, 32'd0);
                end else begin
                    e_pop = q.pop_front();
                    check("sb_data", res_data, e_pop.data);
                    check("sb_ovf", res_overflow, e_pop.ovf);
                    check("sb_sel", res_sel, e_pop.sel);
                    check("sb_divz", res_divz, e_pop.divz);
                end
            end
            if (cmd_valid && cmd_ready) begin
                r = ref_alu(cmd_sel, cmd_a, cmd_b);
                e_push.data = r[15:0];
                e_push.ovf  = r[16];
                e_push.sel  = cmd_sel;
                e_push.divz = (cmd_sel == OP_DIV) && (cmd_b == 16'h0);
                q.push_back(e_push);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [15:0] a,
                        input logic [15:0] b);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) break;
            tick;
        end
        if (!cmd_ready) check("send_timeout", 32'd0, 32'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0 && !busy && !res_valid) return;
            tick;
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    int stale;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid", res_valid, 32'd0);
        check("rst_cmd_ready", cmd_ready, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_ovf_count", ovf_count, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_alu_ina", alu_ina, 32'd0);

        // single add, latency and busy fall
        tick;
        res_ready = 1'b1;
        send(OP_ADD, 16'h0003, 16'h0004);
        @(negedge clk);
        check("lat_edge_n", res_valid, 32'd0);
        @(negedge clk);
        check("lat_edge_n1", res_valid, 32'd0);
        @(negedge clk);
        check("lat_valid", res_valid, 32'd1);
        check("lat_data", res_data, 32'h7);
        check("lat_ovf", res_overflow, 32'd0);
        check("lat_sel", res_sel, 32'd0);
        @(negedge clk);
        check("busy_fall", busy, 32'd0);

        // overflow counting and saturation
        tick;
        send(OP_ADD, 16'hFFFF, 16'h0001);
        drain;
        check("ovf_count_1", ovf_count, 32'd1);
        repeat (300) send(OP_ADD, 16'hFFFF, 16'h0001);
        drain;
        check("ovf_count_sat", ovf_count, 32'hFF);

        // fill the FIFO while the result is stalled
        res_ready = 1'b0;
        send(OP_SUB, 16'h0005, 16'h0002);
        send(OP_ADD, 16'h0010, 16'h0020);
        send(OP_MUL, 16'h0100, 16'h0100);
        send(OP_MUL, 16'h0007, 16'h0009);
        send(OP_SUB, 16'h0001, 16'h0002);
        check("full_ready", cmd_ready, 32'd0);
        cmd_valid = 1'b1;
        cmd_sel   = OP_DIV;
        cmd_a     = 16'h0010;
        cmd_b     = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("stall_ready", cmd_ready, 32'd0);
        end
        check("stall_valid", res_valid, 32'd1);
        check("stall_data", res_data, 32'h3);
        check("stall_ovf", res_overflow, 32'd0);
        check("stall_sel", res_sel, 32'(OP_SUB));
        check("stall_ina", alu_ina, 32'h5);
        check("stall_inb", alu_inb, 32'h2);
        res_ready = 1'b1;
        tick;
        check("ready_reassert", cmd_ready, 32'd1);
        tick;
        cmd_valid = 1'b0;
        drain;

        // divide by zero flag, then a normal divide
        send(OP_DIV, 16'h0010, 16'h0000);
        wait_valid;
        check("divz_sel", res_sel, 32'h3);
        check("divz_flag", res_divz, 32'd1);
        tick;
        send(OP_DIV, 16'h0010, 16'h0002);
        wait_valid;
        check("div_flag", res_divz, 32'd0);
        check("div_data", res_data, 32'h8);
        tick;
        drain;

        // reset while a command settles with two more buffered
        res_ready = 1'b0;
        send(OP_ADD, 16'h0001, 16'h0001);
        wait_valid;
        tick;
        send(OP_ADD, 16'h0002, 16'h0002);
        send(OP_ADD, 16'h0003, 16'h0003);
        send(OP_MUL, 16'hFFFF, 16'hFFFF);
        res_ready = 1'b1;
        tick;
        check("pre_rst_busy", busy, 32'd1);
        rst = 1'b1;
        tick;
        @(negedge clk);
        check("mid_rst_valid", res_valid, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_ready", cmd_ready, 32'd1);
        check("mid_rst_ovf", ovf_count, 32'd0);
        check("mid_rst_ina", alu_ina, 32'd0);
        tick;
        rst   = 1'b0;
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || busy) stale++;
        end
        check("no_stale", stale, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
